// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, NOP word, helpers.
// Build option IFU_MISALIGN_CHK_EN (see inst_fetch_unit) uses is_misaligned().
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_NOP = 32'h0000_0013;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Bundle of the PC, memory and decode handshakes around the fetch unit.
// slave = the fetch unit itself, master = whatever surrounds it.
interface ifu_if #(
  parameter int AW = 32
);
  logic          pc_valid_i;
  logic [AW-1:0] pc_addr_i;
  logic          pc_ready_o;
  logic          flush_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic          inst_valid_o;
  logic [31:0]   inst_o;
  logic [AW-1:0] inst_addr_o;
  logic          inst_err_o;
  logic          inst_ready_i;

  modport slave (
    input  pc_valid_i, pc_addr_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i,
    output pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o, inst_err_o
  );

  modport master (
    output pc_valid_i, pc_addr_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i,
    input  pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o, inst_err_o
  );
endinterface

// File: rtl/ifu_fifo.sv
// Instruction buffer: DEPTH entries of W bits, head readable combinationally.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ifu_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_en;
  logic         pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // A flush overrides any push or pop arriving in the same cycle.
  assign push_en = push_i && !full_o && !flush_i;
  assign pop_en  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
  end

  assign data_o = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetch unit feeding a small decode buffer.
// Define IFU_MISALIGN_CHK_EN to trap misaligned PCs locally instead of fetching them.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic clk,
  input  logic reset_n,
  ifu_if.slave bus
);

  localparam int W = AW + 33;

  ifu_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          misaligned;
  logic          mem_req;
  logic          push;
  logic [31:0]   push_inst;
  logic          push_err;
  logic [W-1:0]  push_data;
  logic [W-1:0]  head_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pc_ready;

`ifdef IFU_MISALIGN_CHK_EN
  assign misaligned     = is_misaligned(addr_q[1:0]);
  assign bus.mem_addr_o = addr_q;
`else
  assign misaligned     = 1'b0;
  assign bus.mem_addr_o = {addr_q[AW-1:2], 2'b00};
`endif

  assign pc_ready = (state_q == IDLE) && !bus.flush_i && !fifo_full;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mem_req   = 1'b0;
    push      = 1'b0;
    push_inst = bus.mem_rdata_i;
    push_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pc_valid_i && pc_ready) begin
          addr_d  = bus.pc_addr_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (misaligned) begin
          // Trapped locally: a NOP tagged with the error bit stands in for the fetch.
          push      = !bus.flush_i;
          push_inst = IFU_NOP;
          push_err  = 1'b1;
          state_d   = IDLE;
        end else begin
          mem_req = 1'b1;
          if (bus.flush_i) begin
            state_d = bus.mem_gnt_i ? DRAIN : IDLE;
          end else if (bus.mem_gnt_i) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid_i) begin
          push    = !bus.flush_i;
          state_d = IDLE;
        end else if (bus.flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign push_data = {addr_q, push_inst, push_err};

  ifu_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (bus.flush_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (bus.inst_ready_i),
    .data_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.pc_ready_o   = pc_ready;
  assign bus.mem_req_o    = mem_req;
  assign bus.inst_valid_o = !fifo_empty;
  assign bus.inst_addr_o  = head_data[W-1 -: AW];
  assign bus.inst_o       = head_data[32:1];
  assign bus.inst_err_o   = head_data[0];

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of instruction-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 pc_valid_i  input  1  PC unit offers an address.
REQ-007 pc_addr_i  input  AW  offered instruction address.
REQ-008 pc_ready_o  output  1  fetch unit accepts the address; feeds the PC unit's ready input.
REQ-009 flush_i  input  1  jump taken; discard all fetched and in-flight instructions.
REQ-010 mem_req_o  output  1  memory read request.
REQ-011 mem_addr_o  output  AW  memory read address.
REQ-012 mem_gnt_i  input  1  memory accepted the request.
REQ-013 mem_rvalid_i  input  1  read data valid.
REQ-014 mem_rdata_i  input  32  read data.
REQ-015 inst_valid_o  output  1  instruction available to decode.
REQ-016 inst_o  output  32  instruction word.
REQ-017 inst_addr_o  output  AW  address of inst_o.
REQ-018 inst_err_o  output  1  misaligned-fetch flag for inst_o.
REQ-019 inst_ready_i  input  1  decode consumes the head entry.

Function
REQ-020 SHALL implement states IDLE, REQ, WAIT, DRAIN.
REQ-021 pc_ready_o SHALL be combinational: 1 only in IDLE, flush_i=0, and buffer not full.
REQ-022 On pc_valid_i & pc_ready_o, SHALL latch pc_addr_i and enter REQ next cycle.
REQ-023 In REQ, SHALL hold mem_req_o=1 and mem_addr_o stable until mem_gnt_i=1, then enter WAIT.
REQ-024 In WAIT, on mem_rvalid_i=1, SHALL push {addr, mem_rdata_i, err=0} into the buffer and return to IDLE.
REQ-025 At most one memory transaction SHALL be outstanding.
REQ-026 Buffer head SHALL drive inst_o/inst_addr_o/inst_err_o combinationally; inst_valid_o = buffer not empty.
REQ-027 Pop on inst_valid_o & inst_ready_i; simultaneous push and pop on a full buffer SHALL NOT be permitted (pc_ready_o already blocks the fetch).
REQ-028 Minimum latency: accept cycle N, mem_req_o cycle N+1, rvalid N+2 earliest, inst_valid_o N+3.
REQ-029 flush_i SHALL empty the buffer at the next edge; inst_valid_o=0 the cycle after.
REQ-030 flush_i in REQ before grant SHALL drop the request (mem_req_o=0 next cycle) and go IDLE; in REQ with same-cycle gnt, or in WAIT without rvalid, SHALL go DRAIN.
REQ-031 DRAIN SHALL discard the next mem_rvalid_i response without pushing, then go IDLE; pc_ready_o=0 in DRAIN.
REQ-032 flush_i in WAIT coincident with mem_rvalid_i SHALL discard that data and go IDLE.
REQ-033 Buffer read/write pointers SHALL wrap modulo DEPTH, with an extra bit for full/empty.

Reset
REQ-034 On reset_n=0: state IDLE, buffer empty, mem_req_o=0, mem_addr_o=0, inst_valid_o=0; pc_ready_o=1 after release.
REQ-035 Reset mid-transaction SHALL abandon it; a late mem_rvalid_i after release in IDLE SHALL be ignored.

Configuration
REQ-036 Macro IFU_MISALIGN_CHK_EN defined: address with addr[1:0]!=0 SHALL NOT issue a memory request; entry pushed next cycle with inst_o=32'h00000013, inst_err_o=1.
REQ-037 Macro undefined: mem_addr_o[1:0] forced to 0, all addresses fetched, inst_err_o tied 0.

Structure
REQ-038 Shared package ifu_pkg SHALL hold state encoding and the NOP constant 32'h00000013.
REQ-039 Instruction buffer SHALL be sub-module ifu_fifo (width AW+33, depth DEPTH).

Verification
REQ-040 Fetch 0x0, gnt immediate, rvalid next cycle data 0x00500093 -> inst_valid_o=1 at N+3, inst_addr_o=0x0, inst_o=0x00500093.
REQ-041 inst_ready_i=0, fetch 0x0,0x4 -> buffer full, pc_ready_o=0 until one pop.
REQ-042 Fetch 0x8, gnt, flush_i in WAIT, rvalid data 0xDEADBEEF -> nothing pushed, inst_valid_o stays 0, then accepts 0x100.
REQ-043 Fetch 0xC with mem_gnt_i=0 three cycles, flush_i -> mem_req_o drops next cycle, state IDLE.
REQ-044 IFU_MISALIGN_CHK_EN, fetch 0x6 -> no mem_req_o, inst_o=0x00000013, inst_err_o=1, inst_addr_o=0x6.
REQ-045 Assert reset_n=0 in WAIT -> all outputs reset; post-reset rvalid ignored.
